// File: rtl/div_if.sv
// Handshake and result bundle between the execute stage and the multi-cycle divider.
interface div_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic             stall;

    modport master (
        output start, is_signed, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero, stall
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero, stall
    );
endinterface

// File: rtl/div_controller.sv
// Radix-2 restoring UDIV/SDIV sequencer, one quotient bit per cycle; done WIDTH+2 cycles after start (1 on divide-by-zero).
// No queueing: start is honoured only in IDLE, and stall freezes fetch/decode while a divide is in flight.
module div_controller #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic clk,
    input  logic reset,
    div_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] prem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             neg_q;
    logic             neg_r;
    logic             dbz;

    logic             accept;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] diff;
    logic             busy;

    assign accept = bus.start && (state == IDLE);
    assign a_neg  = bus.is_signed && bus.dividend[WIDTH-1];
    assign b_neg  = bus.is_signed && bus.divisor[WIDTH-1];
    assign a_mag  = a_neg ? -bus.dividend : bus.dividend;
    assign b_mag  = b_neg ? -bus.divisor  : bus.divisor;

    // The extra top bit keeps the trial exact when the partial remainder
    // exceeds 2^(WIDTH-1); the low-bit difference is exact whenever it fits.
    assign shifted = {prem, dvd[WIDTH-1]};
    assign fits    = shifted >= {1'b0, dvs};
    assign diff    = shifted[WIDTH-1:0] - dvs;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = (bus.divisor == '0) ? DONE : RUN;
            RUN:     if (cnt == CNT_W'(1)) state_nxt = FIXUP;
            FIXUP:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            dvd   <= '0;
            dvs   <= '0;
            prem  <= '0;
            quo   <= '0;
            rem   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dbz   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            quo <= '0;
                            rem <= bus.dividend;
                            dbz <= 1'b1;
                        end else begin
                            dbz   <= 1'b0;
                            dvd   <= a_mag;
                            dvs   <= b_mag;
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                            prem  <= '0;
                            cnt   <= CNT_W'(WIDTH);
                        end
                    end
                end
                RUN: begin
                    // dividend register doubles as the quotient shift register
                    dvd  <= {dvd[WIDTH-2:0], fits};
                    prem <= fits ? diff : shifted[WIDTH-1:0];
                    cnt  <= cnt - CNT_W'(1);
                end
                FIXUP: begin
                    quo <= neg_q ? -dvd : dvd;
                    rem <= neg_r ? -prem : prem;
                end
                default: ;
            endcase
        end
    end

    assign busy            = (state == RUN) || (state == FIXUP);
    assign bus.busy        = busy;
    assign bus.done        = (state == DONE);
    assign bus.stall       = busy || accept;
    assign bus.quotient    = quo;
    assign bus.remainder   = rem;
    assign bus.div_by_zero = dbz;

endmodule

// File: doc/div_controller.md
Name: div_controller

Overview:
- Multi-cycle sequencer for LEGv8 UDIV/SDIV execution; sits beside the execute-stage ALU.
- On a start pulse it captures operands and runs a radix-2 restoring divide, one quotient bit per cycle.
- While a divide is in flight it asserts a stall to fetch/decode so cur_pc holds.
- Delivers quotient (written back as the instruction result) and remainder (kept for MSUB-based modulo sequences).

Parameters:
- WIDTH, `WORD (64): operand/result width in bits.
- CNT_W, 7: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a divide; sampled only in IDLE.
- is_signed  input  1  1 = SDIV (two's complement), 0 = UDIV; captured with start.
- dividend  input  WIDTH  Rn value; captured with start.
- divisor  input  WIDTH  Rm value; captured with start.
- quotient  output  WIDTH  result; valid when done=1, held until the next accepted start.
- remainder  output  WIDTH  remainder, sign of dividend for SDIV; same validity as quotient.
- busy  output  1  high from the cycle after an accepted start through the cycle before done.
- done  output  1  single-cycle pulse, results valid.
- div_by_zero  output  1  set with done when divisor==0; held with results.
- stall  output  1  equals busy OR (start AND state==IDLE); combinational, freezes PC/IF register.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, counter=0, quotient=0, remainder=0, busy=0, done=0, div_by_zero=0. Reset wins over start in the same cycle. Reset mid-operation aborts the divide, and no done is produced.
- States: IDLE, RUN, FIXUP, DONE.
- IDLE:
  - On start, latch is_signed and operands.
  - If divisor==0, go to DONE.
  - Otherwise, latch magnitudes: abs() when is_signed, raw when not. Record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend), signed only. Clear the partial remainder and set counter=WIDTH. Go to RUN.
- RUN:
  - Each cycle, shift {partial_rem, dividend_mag} left by 1.
  - Trial-subtract divisor_mag from the upper WIDTH+1 bits (one extra bit, so WIDTH=64 magnitudes of 2^63 are exact).
  - If non-negative, keep the difference and shift in quotient bit 1; else restore and shift in 0.
  - Decrement counter. When counter reaches 1 on this edge, go to FIXUP. RUN lasts exactly WIDTH cycles.
- FIXUP (1 cycle):
  - quotient = neg_q ? -q : q.
  - remainder = neg_r ? -r : r.
  - All arithmetic is mod 2^WIDTH.
  - Signed overflow (MIN / -1) naturally yields quotient = MIN and remainder = 0, matching ARMv8. No trap is raised.
- DONE (1 cycle):
  - done=1, busy=0, then return to IDLE.
  - Divide by zero: quotient=0, remainder=dividend, div_by_zero=1 (ARMv8 returns 0, no exception).
- Latency from the accepted start edge to done:
  - Normal divide: WIDTH+2 cycles (66 for 64-bit).
  - Divide by zero: 1 cycle.
- Handshake and output rules:
  - start while busy or in DONE is ignored; there is no queueing.
  - start in the same cycle done is high is ignored. The requester must re-issue after done.
  - quotient, remainder and div_by_zero change only in FIXUP, DONE (zero case) or reset. They hold otherwise, and are cleared to 0 only by reset.
  - div_by_zero clears on the next accepted start.

Test Plan:
- UDIV 100/7 (the reference division program's operands): start pulse -> busy for 65 cycles; done pulse 66 cycles after start; quotient=14, remainder=2, div_by_zero=0; stall high from the start cycle to the cycle before done.
- SDIV -100/7 -> quotient=-14 (0xFFFF_FFFF_FFFF_FFF2), remainder=-2. Then SDIV 100/-7 -> quotient=-14, remainder=2.
- Divisor zero: UDIV 55/0 -> done 1 cycle after start; quotient=0, remainder=55, div_by_zero=1, busy never high.
- Boundaries:
  - SDIV 0x8000_0000_0000_0000 / -1 -> quotient=0x8000_0000_0000_0000, remainder=0.
  - UDIV 0xFFFF_FFFF_FFFF_FFFF / 1 -> quotient=all ones, remainder=0.
  - UDIV 3/0xFFFF_FFFF_FFFF_FFFF -> quotient=0, remainder=3.
- Protocol:
  - Second start at cycle 10 of a running divide -> ignored; first result intact, exactly one done.
  - reset at cycle 30 -> all outputs 0, state IDLE, no done.
  - A fresh start one cycle after reset deasserts completes normally (21/4 -> quotient=5, remainder=1).
